muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative HI/LO multiply/divide unit beside the multicycle datapath.
- Executes mult, multu, div and divu using the registered rs/rt operands (rf_rd_data1_reg, rf_rd_data2_reg).
- Services mthi/mtlo writes and exposes HI/LO for mfhi/mflo.
- The control FSM holds in its execute state while busy is high, and checks busy before issuing mfhi/mflo.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- ITERS, WIDTH, number of shift-add or shift-subtract iterations; must equal WIDTH.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request, sampled only when busy=0.
- op  in  2  operation: 0 mult, 1 multu, 2 div, 3 divu; sampled with start.
- op1  in  WIDTH  rs value (multiplicand or dividend); sampled with start.
- op2  in  WIDTH  rt value (multiplier or divisor); sampled with start.
- hi_wr  in  1  mthi write strobe.
- lo_wr  in  1  mtlo write strobe.
- wdata  in  WIDTH  write data for mthi/mtlo.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse; HI/LO have just been updated by a completed operation.

Behaviour:
- Reset (async, any time, including mid-operation):
  - hi=0, lo=0, busy=0, done=0, state=IDLE, iteration counter=0.
  - Any in-flight operation is discarded.
- States:
  - IDLE: start=1 at edge E0 → latch op; latch |op1|,|op2| (signed ops) or raw values (unsigned ops); latch the sign flags; clear the accumulator; counter=0; → CALC.
  - CALC: one iteration per edge. After the 32nd iteration (edge E32) → FIX.
  - FIX: at edge E33, apply sign correction and write HI/LO; → IDLE; done=1 for the cycle after E33.
- Timing:
  - busy = (state != IDLE), registered. It is high from after E0 until E33, i.e. 33 cycles.
  - Start-to-result latency is exactly 33 cycles for every op, including divide by zero.
- Multiply:
  - Unsigned 32x32 shift-add giving a 64-bit product; hi=product[63:32], lo=product[31:0].
  - mult: the product is two's-complement negated when the operand signs differ.
- Divide:
  - Restoring shift-subtract on unsigned magnitudes; lo=quotient, hi=remainder.
  - div: quotient is negated when the signs differ; remainder takes the sign of the dividend.
  - Divide by zero (div or divu): lo=32'hFFFF_FFFF, hi=op1 as latched; no exception.
  - div 0x8000_0000 / 0xFFFF_FFFF: lo=0x8000_0000, hi=0 (natural wrap); no exception.
- Start rules:
  - start while busy=1: ignored; no effect on the current operation.
  - start and done in the same cycle: accepted (busy=0 by then). Back-to-back operations are therefore 34 cycles apart.
- mthi/mtlo:
  - Write at the next edge when busy=0.
  - Ignored when busy=1; the control FSM must not issue them while busy.
  - hi_wr/lo_wr in the same cycle as an accepted start: the write takes effect, then is overwritten by the result at E33.
  - hi_wr and lo_wr together: both registers are written with wdata.
- Outputs hi/lo hold their previous values during CALC and change only at FIX or on an mthi/mtlo write.
- No X propagation: an illegal state returns to IDLE.

Decomposition:
- Package muldiv_pkg holds:
  - op encodings OP_MULT=2'd0, OP_MULTU=2'd1, OP_DIV=2'd2, OP_DIVU=2'd3;
  - state encoding IDLE/CALC/FIX;
  - WIDTH default.
- Single module; no sub-module is natural, since the shared 64-bit accumulator and counter serve both multiply and divide.

Test Plan:
- mult op1=0xFFFF_FFFE (-2), op2=3 → after 33 cycles hi=0xFFFF_FFFF, lo=0xFFFF_FFFA; done one cycle; busy high exactly 33 cycles.
- multu op1=0xFFFF_FFFF, op2=0xFFFF_FFFF → hi=0xFFFF_FFFE, lo=0x0000_0001.
- div op1=-7 (0xFFFF_FFF9), op2=2 → lo=0xFFFF_FFFD (-3), hi=0xFFFF_FFFF (-1); divu op1=7, op2=0 → lo=0xFFFF_FFFF, hi=7.
- div op1=0x8000_0000, op2=0xFFFF_FFFF → lo=0x8000_0000, hi=0; no hang, done at cycle 33.
- mthi wdata=0x1234 while idle → hi=0x1234 next cycle. Then start multu 5x6, and assert mtlo 0xAAAA and a second start while busy → both ignored; final hi=0, lo=30.
- Assert rst at cycle 10 of a div → hi=lo=0, busy=0, done never pulses. A new start after reset completes normally in 33 cycles.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit.
package muldiv_pkg;

    localparam int unsigned WIDTH_DEFAULT = 32;

    localparam logic [1:0] OP_MULT  = 2'd0;
    localparam logic [1:0] OP_MULTU = 2'd1;
    localparam logic [1:0] OP_DIV   = 2'd2;
    localparam logic [1:0] OP_DIVU  = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: shift-add multiply, restoring divide,
// sign handled on magnitudes with a final correction step.
module muldiv_unit #(
    parameter int unsigned WIDTH = muldiv_pkg::WIDTH_DEFAULT,
    parameter int unsigned ITERS = WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic             hi_wr,
    input  logic             lo_wr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);
    import muldiv_pkg::*;

    localparam int unsigned CNT_W = $clog2(ITERS + 1);
    localparam int unsigned ACC_W = 2 * WIDTH;

    state_t             state_q, state_nxt;
    logic [CNT_W-1:0]   cnt_q, cnt_nxt;
    logic [ACC_W-1:0]   acc_q, acc_nxt;
    logic [WIDTH-1:0]   b_q, b_nxt;
    logic               is_div_q, is_div_nxt;
    logic               neg_q, neg_nxt;
    logic               neg_rem_q, neg_rem_nxt;
    logic               dz_q, dz_nxt;
    logic [WIDTH-1:0]   hi_nxt, lo_nxt;
    logic               busy_nxt, done_nxt;

    // Operand magnitudes at issue; unsigned ops (op[0]=1) pass raw values.
    logic             sgn_op;
    logic [WIDTH-1:0] mag1, mag2;
    assign sgn_op = ~op[0];
    assign mag1   = (sgn_op && op1[WIDTH-1]) ? (~op1 + 1'b1) : op1;
    assign mag2   = (sgn_op && op2[WIDTH-1]) ? (~op2 + 1'b1) : op2;

    // Multiply step: conditional add into the upper half, then shift right with carry.
    logic [WIDTH:0]   mul_sum;
    logic [ACC_W-1:0] mul_step;
    assign mul_sum  = {1'b0, acc_q[ACC_W-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
    assign mul_step = {mul_sum, acc_q[WIDTH-1:1]};

    // Restoring divide step: remainder lives in the upper half, quotient shifts into the lower.
    logic [WIDTH:0]   div_sh, div_diff;
    logic [ACC_W-1:0] div_step;
    assign div_sh   = {acc_q[ACC_W-1:WIDTH], acc_q[WIDTH-1]};
    assign div_diff = div_sh - {1'b0, b_q};
    assign div_step = div_diff[WIDTH]
                    ? {div_sh[WIDTH-1:0],   acc_q[WIDTH-2:0], 1'b0}
                    : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

    logic [ACC_W-1:0] prod_fix;
    logic [WIDTH-1:0] quo, rem, quo_fix, rem_fix;
    assign prod_fix = neg_q ? (~acc_q + 1'b1) : acc_q;
    assign quo      = acc_q[WIDTH-1:0];
    assign rem      = acc_q[ACC_W-1:WIDTH];
    assign quo_fix  = dz_q ? '1 : (neg_q ? (~quo + 1'b1) : quo);
    assign rem_fix  = neg_rem_q ? (~rem + 1'b1) : rem;

    always_comb begin
        state_nxt   = state_q;
        cnt_nxt     = cnt_q;
        acc_nxt     = acc_q;
        b_nxt       = b_q;
        is_div_nxt  = is_div_q;
        neg_nxt     = neg_q;
        neg_rem_nxt = neg_rem_q;
        dz_nxt      = dz_q;
        hi_nxt      = hi;
        lo_nxt      = lo;
        done_nxt    = 1'b0;

        case (state_q)
            IDLE: begin
                if (hi_wr) hi_nxt = wdata;
                if (lo_wr) lo_nxt = wdata;
                if (start) begin
                    is_div_nxt  = op[1];
                    neg_nxt     = sgn_op & (op1[WIDTH-1] ^ op2[WIDTH-1]);
                    neg_rem_nxt = sgn_op & op1[WIDTH-1];
                    dz_nxt      = (op2 == '0);
                    cnt_nxt     = '0;
                    if (op[1]) begin
                        acc_nxt = {{WIDTH{1'b0}}, mag1};
                        b_nxt   = mag2;
                    end else begin
                        acc_nxt = {{WIDTH{1'b0}}, mag2};
                        b_nxt   = mag1;
                    end
                    state_nxt = CALC;
                end
            end
            CALC: begin
                acc_nxt = is_div_q ? div_step : mul_step;
                cnt_nxt = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(ITERS - 1)) state_nxt = FIX;
            end
            FIX: begin
                if (is_div_q) begin
                    hi_nxt = rem_fix;
                    lo_nxt = quo_fix;
                end else begin
                    hi_nxt = prod_fix[ACC_W-1:WIDTH];
                    lo_nxt = prod_fix[WIDTH-1:0];
                end
                done_nxt  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy_nxt = (state_nxt != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            b_q       <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            hi        <= '0;
            lo        <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            cnt_q     <= cnt_nxt;
            acc_q     <= acc_nxt;
            b_q       <= b_nxt;
            is_div_q  <= is_div_nxt;
            neg_q     <= neg_nxt;
            neg_rem_q <= neg_rem_nxt;
            dz_q      <= dz_nxt;
            hi        <= hi_nxt;
            lo        <= lo_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] op1, op2;
    logic        hi_wr, lo_wr;
    logic [31:0] wdata;
    logic [31:0] hi, lo;
    logic        busy, done;

    int n_tests = 0;
    int n_fail  = 0;

    muldiv_unit dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .op1   (op1),
        .op2   (op2),
        .hi_wr (hi_wr),
        .lo_wr (lo_wr),
        .wdata (wdata),
        .hi    (hi),
        .lo    (lo),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        op    = o;
        op1   = a;
        op2   = b;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Counts cycles from just after the issue edge until done; bounded.
    task automatic wait_done(output int lat, output int bc);
        lat = 0;
        bc  = 0;
        while (!done && lat < 40) begin
            if (busy) bc++;
            tick();
            lat++;
        end
    endtask

    task automatic run(input string tag, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int lat, bc;
        launch(o, a, b);
        check({tag, ".busy_on"}, 32'(busy), 32'd1);
        check({tag, ".done_low"}, 32'(done), 32'd0);
        wait_done(lat, bc);
        check({tag, ".latency"}, 32'(lat), 32'd33);
        check({tag, ".busy_cycles"}, 32'(bc), 32'd33);
        check({tag, ".hi"}, hi, exp_hi);
        check({tag, ".lo"}, lo, exp_lo);
        check({tag, ".busy_off"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int lat, bc, pulses;
        rst   = 1'b1;
        start = 1'b0;
        op    = OP_MULT;
        op1   = '0;
        op2   = '0;
        hi_wr = 1'b0;
        lo_wr = 1'b0;
        wdata = '0;
        tick();
        tick();
        check("reset.hi", hi, 32'h0);
        check("reset.lo", lo, 32'h0);
        check("reset.busy", 32'(busy), 32'd0);
        check("reset.done", 32'(done), 32'd0);
        rst = 1'b0;
        tick();

        // Consecutive runs issue start during the done cycle (back-to-back).
        run("mult_neg2x3",  OP_MULT,  32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run("multu_max",    OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run("mult_7xneg3",  OP_MULT,  32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run("div_neg7_2",   OP_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run("div_7_neg2",   OP_DIV,   32'd7,        32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
        run("divu_7_0",     OP_DIVU,  32'd7,        32'd0,        32'h0000_0007, 32'hFFFF_FFFF);
        run("div_neg7_0",   OP_DIV,   32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, 32'hFFFF_FFFF);
        run("div_min_neg1", OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        run("divu_100_7",   OP_DIVU,  32'd100,      32'd7,        32'h0000_0002, 32'h0000_000E);
        tick();
        check("done_pulse_width", 32'(done), 32'd0);

        // mthi while idle, then writes and a second start while busy are ignored.
        hi_wr = 1'b1;
        wdata = 32'h0000_1234;
        tick();
        hi_wr = 1'b0;
        check("mthi.hi", hi, 32'h0000_1234);
        check("mthi.lo_kept", lo, 32'h0000_000E);
        launch(OP_MULTU, 32'd5, 32'd6);
        lo_wr = 1'b1;
        wdata = 32'h0000_AAAA;
        start = 1'b1;
        op    = OP_DIVU;
        op1   = 32'd100;
        op2   = 32'd0;
        tick();
        lo_wr = 1'b0;
        start = 1'b0;
        check("busy_ign.hi_held", hi, 32'h0000_1234);
        check("busy_ign.lo_held", lo, 32'h0000_000E);
        wait_done(lat, bc);
        check("busy_ign.latency", 32'(lat), 32'd32);
        check("busy_ign.hi", hi, 32'h0000_0000);
        check("busy_ign.lo", lo, 32'h0000_001E);
        tick();

        // Writes in the issue cycle land, then the result overwrites them.
        hi_wr = 1'b1;
        lo_wr = 1'b1;
        wdata = 32'h0000_5555;
        launch(OP_MULTU, 32'd2, 32'd3);
        hi_wr = 1'b0;
        lo_wr = 1'b0;
        check("wr_start.hi_mid", hi, 32'h0000_5555);
        check("wr_start.lo_mid", lo, 32'h0000_5555);
        wait_done(lat, bc);
        check("wr_start.latency", 32'(lat), 32'd33);
        check("wr_start.hi", hi, 32'h0000_0000);
        check("wr_start.lo", lo, 32'h0000_0006);
        tick();

        // Asynchronous reset in the middle of a divide.
        launch(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        repeat (9) tick();
        rst = 1'b1;
        #1;
        check("midrst.hi", hi, 32'h0);
        check("midrst.lo", lo, 32'h0);
        check("midrst.busy", 32'(busy), 32'd0);
        check("midrst.done", 32'(done), 32'd0);
        tick();
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) pulses++;
            tick();
        end
        check("midrst.no_done", 32'(pulses), 32'd0);
        check("midrst.idle", 32'(busy), 32'd0);
        run("after_rst_divu", OP_DIVU, 32'd100, 32'd7, 32'h0000_0002, 32'h0000_000E);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
